// File: rtl/pc_unit.sv
// pc_unit: RV32I program counter with boot sequencing, misaligned-target trap and return-address stack.
module pc_unit #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100,
  parameter int              RAS_DEPTH    = 4,
  parameter int              C_EXT        = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            advance,
  input  logic            stall,
  input  logic [1:0]      pc_src,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] alu_result,
  input  logic            is_call,
  input  logic            is_ret,
  input  logic            trap_ack,
  output logic [XLEN-1:0] pc,
  output logic            pc_valid,
  output logic [XLEN-1:0] pc_plus4,
  output logic            trap_valid,
  output logic [XLEN-1:0] trap_epc,
  output logic [XLEN-1:0] trap_tval,
  output logic [XLEN-1:0] ras_top,
  output logic            ras_valid
);
  localparam int AW = $clog2(RAS_DEPTH);
  typedef enum logic [1:0] {BOOT, RUN, TRAP} state_t;
  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, epc_q, epc_d, tval_q, tval_d;
  logic [XLEN-1:0] ras_q [RAS_DEPTH];
  logic [XLEN-1:0] ras_d [RAS_DEPTH];
  logic [AW-1:0]   ptr_q, ptr_d;
  logic [AW:0]     cnt_q, cnt_d;
  logic            pc_valid_q, pc_valid_d, trap_valid_q, trap_valid_d;
  logic [XLEN-1:0] jalr_sum, target;
  logic            taken, misaligned, retire, link, push, pop, repl;
  assign pc_plus4 = pc_q + XLEN'(4);
  assign jalr_sum = rs1 + imm;
  assign taken    = alu_result == XLEN'(1);
  assign target   = pc_src == 2'b00 ? {jalr_sum[XLEN-1:1], 1'b0} :
                    (pc_src == 2'b01 || (pc_src == 2'b10 && taken)) ? pc_q + imm : pc_plus4;
  assign misaligned = (C_EXT == 0) && target[1];
  assign retire     = state_q == RUN && advance && !stall;
  // Only JAL/JALR (pc_src[1]==0) that actually retire without faulting touch the stack
  assign link = retire && !misaligned && !pc_src[1];
  assign push = link && is_call && (!is_ret || cnt_q == '0);
  assign pop  = link && is_ret && !is_call && cnt_q != '0;
  assign repl = link && is_call && is_ret && cnt_q != '0;
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    epc_d   = epc_q;
    tval_d  = tval_q;
    ras_d   = ras_q;
    ptr_d   = ptr_q + AW'(push) - AW'(pop);
    cnt_d   = push ? (cnt_q == (AW+1)'(RAS_DEPTH) ? cnt_q : cnt_q + 1'b1) : pop ? cnt_q - 1'b1 : cnt_q;
    if (push || repl) ras_d[ptr_d] = pc_plus4;
    if (state_q == BOOT) state_d = RUN;
    if (state_q == TRAP && trap_ack) state_d = RUN;
    if (retire && misaligned) begin
      state_d = TRAP;
      pc_d    = TRAP_VECTOR;
      epc_d   = pc_q;
      tval_d  = target;
      cnt_d   = '0;
    end else if (retire) begin
      pc_d = target;
    end
    pc_valid_d   = state_d == RUN;
    trap_valid_d = state_d == TRAP;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= BOOT;
      pc_q         <= RESET_VECTOR;
      epc_q        <= '0;
      tval_q       <= '0;
      ptr_q        <= '0;
      cnt_q        <= '0;
      pc_valid_q   <= 1'b0;
      trap_valid_q <= 1'b0;
      for (int i = 0; i < RAS_DEPTH; i++) ras_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      epc_q        <= epc_d;
      tval_q       <= tval_d;
      ptr_q        <= ptr_d;
      cnt_q        <= cnt_d;
      pc_valid_q   <= pc_valid_d;
      trap_valid_q <= trap_valid_d;
      ras_q        <= ras_d;
    end
  end
  assign pc         = pc_q;
  assign pc_valid   = pc_valid_q;
  assign trap_valid = trap_valid_q;
  assign trap_epc   = epc_q;
  assign trap_tval  = tval_q;
  assign ras_valid  = cnt_q != '0;
  assign ras_top    = cnt_q == '0 ? '0 : ras_q[ptr_q];
endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed self-checking bench for pc_unit.
module tb_pc_unit;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        advance = 1'b0, stall = 1'b0, is_call = 1'b0, is_ret = 1'b0, trap_ack = 1'b0;
  logic [1:0]  pc_src = 2'b11;
  logic [31:0] rs1 = '0, imm = '0, alu_result = '0;
  logic [31:0] pc, pc_plus4, trap_epc, trap_tval, ras_top;
  logic        pc_valid, trap_valid, ras_valid;
  int checks = 0, errors = 0;

  pc_unit dut (
    .clk(clk), .rst_n(rst_n), .advance(advance), .stall(stall), .pc_src(pc_src),
    .rs1(rs1), .imm(imm), .alu_result(alu_result), .is_call(is_call), .is_ret(is_ret),
    .trap_ack(trap_ack), .pc(pc), .pc_valid(pc_valid), .pc_plus4(pc_plus4),
    .trap_valid(trap_valid), .trap_epc(trap_epc), .trap_tval(trap_tval),
    .ras_top(ras_top), .ras_valid(ras_valid)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    advance = 0; stall = 0; is_call = 0; is_ret = 0; trap_ack = 0; pc_src = 2'b11;
  endtask

  task automatic jump(input logic [1:0] src, input logic [31:0] r, input logic [31:0] i,
                      input logic c, input logic rt);
    pc_src = src; rs1 = r; imm = i; is_call = c; is_ret = rt; advance = 1;
    step();
    idle();
  endtask

  task automatic test_reset();
    idle();
    rst_n = 0;
    repeat (3) step();
    checks++; if (pc !== 32'h0 || pc_valid !== 1'b0) begin errors++; $display("FAIL reset_pc got pc=%h valid=%b exp pc=0 valid=0", pc, pc_valid); end
    checks++; if (trap_valid !== 1'b0 || trap_epc !== 32'h0 || trap_tval !== 32'h0) begin errors++; $display("FAIL reset_trap got %b %h %h exp 0 0 0", trap_valid, trap_epc, trap_tval); end
    checks++; if (ras_valid !== 1'b0 || ras_top !== 32'h0) begin errors++; $display("FAIL reset_ras got %b %h exp 0 0", ras_valid, ras_top); end
    @(negedge clk);
    rst_n = 1;
    #1;
    checks++; if (pc_valid !== 1'b0) begin errors++; $display("FAIL boot_valid got %b exp 0", pc_valid); end
    step();
    checks++; if (pc !== 32'h0 || pc_valid !== 1'b1) begin errors++; $display("FAIL run_entry got pc=%h valid=%b exp 0 1", pc, pc_valid); end
    advance = 1;
    step();
    checks++; if (pc !== 32'h4) begin errors++; $display("FAIL seq1 got %h exp 4", pc); end
    step();
    checks++; if (pc !== 32'h8 || pc_plus4 !== 32'hC) begin errors++; $display("FAIL seq2 got %h/%h exp 8/c", pc, pc_plus4); end
    idle();
  endtask

  task automatic test_jal_branch();
    jump(2'b00, 32'h40, 32'h0, 0, 0);
    checks++; if (pc !== 32'h40) begin errors++; $display("FAIL jalr_setup got %h exp 40", pc); end
    jump(2'b01, 32'h0, 32'hFFFF_FFF0, 0, 0);
    checks++; if (pc !== 32'h30) begin errors++; $display("FAIL jal_neg got %h exp 30", pc); end
    alu_result = 0;
    jump(2'b10, 32'h0, 32'hFFFF_FFF0, 0, 0);
    checks++; if (pc !== 32'h34) begin errors++; $display("FAIL br_not_taken got %h exp 34", pc); end
    alu_result = 1;
    jump(2'b10, 32'h0, 32'h8, 0, 0);
    checks++; if (pc !== 32'h3C) begin errors++; $display("FAIL br_taken got %h exp 3c", pc); end
    alu_result = 3;
    jump(2'b10, 32'h0, 32'h8, 0, 0);
    checks++; if (pc !== 32'h40) begin errors++; $display("FAIL br_alu3 got %h exp 40", pc); end
    alu_result = 0;
  endtask

  task automatic test_jalr_stall();
    jump(2'b00, 32'h101, 32'h0, 0, 0);
    checks++; if (pc !== 32'h100) begin errors++; $display("FAIL jalr_clr got %h exp 100", pc); end
    stall = 1; advance = 1; pc_src = 2'b11;
    repeat (3) step();
    checks++; if (pc !== 32'h100) begin errors++; $display("FAIL stall_hold got %h exp 100", pc); end
    idle();
    step();
    checks++; if (pc !== 32'h100) begin errors++; $display("FAIL noadv_hold got %h exp 100", pc); end
  endtask

  task automatic test_trap();
    jump(2'b00, 32'h20, 32'h0, 1, 0);
    checks++; if (pc !== 32'h20 || ras_valid !== 1'b1 || ras_top !== 32'h104) begin errors++; $display("FAIL pre_trap got pc=%h rv=%b rt=%h exp 20 1 104", pc, ras_valid, ras_top); end
    jump(2'b00, 32'h202, 32'h0, 0, 0);
    checks++; if (pc !== 32'h100 || trap_valid !== 1'b1 || pc_valid !== 1'b0) begin errors++; $display("FAIL trap_enter got pc=%h tv=%b pv=%b exp 100 1 0", pc, trap_valid, pc_valid); end
    checks++; if (trap_epc !== 32'h20 || trap_tval !== 32'h202) begin errors++; $display("FAIL trap_info got %h %h exp 20 202", trap_epc, trap_tval); end
    checks++; if (ras_valid !== 1'b0) begin errors++; $display("FAIL trap_flush got %b exp 0", ras_valid); end
    advance = 1; pc_src = 2'b11;
    step();
    checks++; if (pc !== 32'h100 || trap_valid !== 1'b1) begin errors++; $display("FAIL trap_hold got %h %b exp 100 1", pc, trap_valid); end
    idle();
    trap_ack = 1;
    step();
    trap_ack = 0;
    checks++; if (trap_valid !== 1'b0 || pc_valid !== 1'b1 || pc !== 32'h100) begin errors++; $display("FAIL trap_ack got tv=%b pv=%b pc=%h exp 0 1 100", trap_valid, pc_valid, pc); end
  endtask

  task automatic test_ras();
    logic [31:0] exp_top [4] = '{32'h34, 32'h24, 32'h14, 32'h0};
    jump(2'b00, 32'h0, 32'h0, 0, 0);
    for (int i = 0; i < 5; i++) jump(2'b01, 32'h0, 32'h10, 1, 0);
    checks++; if (ras_top !== 32'h44 || ras_valid !== 1'b1 || pc !== 32'h50) begin errors++; $display("FAIL ras_full got top=%h v=%b pc=%h exp 44 1 50", ras_top, ras_valid, pc); end
    for (int i = 0; i < 4; i++) begin
      jump(2'b00, 32'h200, 32'h0, 0, 1);
      checks++; if (ras_top !== exp_top[i] || ras_valid !== (i < 3)) begin errors++; $display("FAIL ras_pop%0d got %h/%b exp %h/%b", i, ras_top, ras_valid, exp_top[i], i < 3); end
    end
    jump(2'b00, 32'h200, 32'h0, 0, 1);
    checks++; if (ras_valid !== 1'b0 || ras_top !== 32'h0) begin errors++; $display("FAIL ras_empty_pop got %b %h exp 0 0", ras_valid, ras_top); end
    jump(2'b11, 32'h0, 32'h0, 1, 0);
    checks++; if (ras_valid !== 1'b0 || pc !== 32'h204) begin errors++; $display("FAIL ras_seq_ignore got %b pc=%h exp 0 204", ras_valid, pc); end
    jump(2'b01, 32'h0, 32'h10, 1, 0);
    jump(2'b00, 32'h300, 32'h0, 1, 1);
    checks++; if (ras_top !== 32'h218 || pc !== 32'h300) begin errors++; $display("FAIL ras_replace got %h pc=%h exp 218 300", ras_top, pc); end
    jump(2'b00, 32'h400, 32'h0, 0, 1);
    checks++; if (ras_valid !== 1'b0) begin errors++; $display("FAIL ras_replace_cnt got %b exp 0", ras_valid); end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) jump(2'b01, 32'h0, 32'h10, 1, 0);
    checks++; if (ras_valid !== 1'b1 || ras_top !== 32'h424) begin errors++; $display("FAIL ras3 got %b %h exp 1 424", ras_valid, ras_top); end
    jump(2'b00, 32'h2, 32'h0, 0, 0);
    checks++; if (trap_valid !== 1'b1) begin errors++; $display("FAIL async_pre got %b exp 1", trap_valid); end
    #2 rst_n = 0;
    #1;
    checks++; if (pc !== 32'h0 || trap_valid !== 1'b0 || trap_epc !== 32'h0 || trap_tval !== 32'h0 || ras_valid !== 1'b0 || pc_valid !== 1'b0) begin
      errors++; $display("FAIL async_reset got pc=%h tv=%b epc=%h tval=%h rv=%b pv=%b exp all 0", pc, trap_valid, trap_epc, trap_tval, ras_valid, pc_valid);
    end
    @(negedge clk);
    rst_n = 1;
    step();
    advance = 1;
    step();
    idle();
    checks++; if (pc !== 32'h4 || pc_valid !== 1'b1) begin errors++; $display("FAIL post_reset got %h %b exp 4 1", pc, pc_valid); end
  endtask

  initial begin
    test_reset();
    test_jal_branch();
    test_jalr_stall();
    test_trap();
    test_ras();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
